// File: rtl/mem_region_mapper_pkg.sv
// ---------------------------------------------------------------------------
// mem_region_mapper_pkg
// Shared definitions for the memory region mapper:
//   - XLEN encoding (word width W = 1 << (XLEN + 4); 2 selects 64-bit words)
//   - config field codes written on i_cfg_field
//   - fault cause codes reported on o_fault_cause
//   - bit positions inside the 4-bit {L,X,W,R} permission field
//   - fault-capture FSM state type
// ---------------------------------------------------------------------------
package mem_region_mapper_pkg;

    localparam int XLEN_64b = 2;

    localparam logic [1:0] FIELD_BASE  = 2'd0;
    localparam logic [1:0] FIELD_LIMIT = 2'd1;
    localparam logic [1:0] FIELD_PERM  = 2'd2;

    localparam logic [1:0] CAUSE_FETCH = 2'd0;
    localparam logic [1:0] CAUSE_LOAD  = 2'd1;
    localparam logic [1:0] CAUSE_STORE = 2'd2;

    localparam int PERM_R = 0;
    localparam int PERM_W = 1;
    localparam int PERM_X = 2;
    localparam int PERM_L = 3;

    typedef enum logic {
        FAULT_IDLE = 1'b0,
        FAULT_HELD = 1'b1
    } fault_state_e;

endpackage

// File: rtl/mem_region_match.sv
// ---------------------------------------------------------------------------
// mem_region_match
// Single-region address compare and permission check (purely combinational).
// Ports:
//   addr     in  W  address being looked up
//   base     in  W  region base (inclusive)
//   limit    in  W  region limit (inclusive)
//   perm     in  3  {X,W,R} permission bits of the region
//   hit      out 1  base <= addr <= limit (unsigned)
//   allow_x  out 1  hit and executable
//   allow_r  out 1  hit and readable
//   allow_w  out 1  hit and writable
//   offset   out W  addr - base (mod 2^W), meaningful only on hit
// ---------------------------------------------------------------------------
module mem_region_match
    import mem_region_mapper_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] addr,
    input  logic [W-1:0] base,
    input  logic [W-1:0] limit,
    input  logic [2:0]   perm,
    output logic         hit,
    output logic         allow_x,
    output logic         allow_r,
    output logic         allow_w,
    output logic [W-1:0] offset
);

    assign hit     = (addr >= base) && (addr <= limit);
    assign allow_x = hit & perm[PERM_X];
    assign allow_r = hit & perm[PERM_R];
    assign allow_w = hit & perm[PERM_W];
    assign offset  = addr - base;

endmodule

// File: rtl/mem_region_mapper.sv
// ---------------------------------------------------------------------------
// mem_region_mapper
// Programmable base/limit region table with registered fetch and execute
// lookups, address translation (addr - base of winning region), permission
// checking and a sticky fault-capture register.
//
// Build option: define MEM_REGION_LOCK_EN to honour the per-region lock bit
// (perm bit L). When undefined, L is always stored as 0.
//
// Ports:
//   i_clk, i_rst                clock, asynchronous active-high reset
//   i_cfg_we/idx/field/wdata    region table write (field 0 base, 1 limit,
//                               2 perm using wdata[3:0] = {L,X,W,R})
//   o_cfg_err                   one-cycle pulse for a rejected write
//   i_fetch_addr, i_ex_addr     lookup addresses
//   i_lw_e, i_sw_e              load / store strobes for the ex lookup
//   i_stall                     hold all lookup outputs
//   o_fetch_sel, o_ex_sel       one-hot winning region (0 on miss)
//   o_*_translated_addr         addr - winning base, raw addr on miss
//   o_bad_addr_f/_load_e/_store_e  registered permission violations
//   o_fault_valid/cause/addr    first captured fault, i_fault_clr releases
// ---------------------------------------------------------------------------
module mem_region_mapper
    import mem_region_mapper_pkg::*;
#(
    parameter int XLEN      = XLEN_64b,
    parameter int N_REGIONS = 4,
    localparam int W        = 1 << (XLEN + 4),
    parameter logic [N_REGIONS*W-1:0] RESET_BASE  =
        {W'(64'h1), W'(64'h2000), W'(64'h1000), W'(64'h0)},
    parameter logic [N_REGIONS*W-1:0] RESET_LIMIT =
        {W'(64'h0), W'(64'h2FFF), W'(64'h1FFF), W'(64'hFFF)},
    parameter logic [N_REGIONS*4-1:0] RESET_PERM  =
        {4'b0000, 4'b0011, 4'b0001, 4'b0101}
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cfg_we,
    input  logic [2:0]           i_cfg_idx,
    input  logic [1:0]           i_cfg_field,
    input  logic [W-1:0]         i_cfg_wdata,
    output logic                 o_cfg_err,
    input  logic [W-1:0]         i_fetch_addr,
    input  logic [W-1:0]         i_ex_addr,
    input  logic                 i_lw_e,
    input  logic                 i_sw_e,
    input  logic                 i_stall,
    output logic [N_REGIONS-1:0] o_fetch_sel,
    output logic [N_REGIONS-1:0] o_ex_sel,
    output logic [W-1:0]         o_fetch_translated_addr,
    output logic [W-1:0]         o_ex_translated_addr,
    output logic                 o_bad_addr_f,
    output logic                 o_bad_addr_load_e,
    output logic                 o_bad_addr_store_e,
    output logic                 o_fault_valid,
    output logic [1:0]           o_fault_cause,
    output logic [W-1:0]         o_fault_addr,
    input  logic                 i_fault_clr
);

`ifdef MEM_REGION_LOCK_EN
    localparam logic [3:0] PERM_MASK = 4'b1111;
`else
    // L is forced to 0 so the lock check below can never fire.
    localparam logic [3:0] PERM_MASK = 4'b0111;
`endif

    // ---------------- region table ----------------
    logic [W-1:0] base_reg  [N_REGIONS];
    logic [W-1:0] limit_reg [N_REGIONS];
    logic [3:0]   perm_reg  [N_REGIONS];

    logic [N_REGIONS-1:0] idx_hit_vec;
    logic [N_REGIONS-1:0] locked_vec;
    logic                 idx_valid;
    logic                 cfg_accept;
    logic                 cfg_err_reg;

    // Per-region lookup results
    logic [N_REGIONS-1:0] f_hit, f_allow_x, f_unused_r, f_unused_w;
    logic [N_REGIONS-1:0] ex_hit, ex_allow_r, ex_allow_w, ex_unused_x;
    logic [W-1:0]         f_offset  [N_REGIONS];
    logic [W-1:0]         ex_offset [N_REGIONS];

    genvar gi;
    generate
        for (gi = 0; gi < N_REGIONS; gi++) begin : g_region
            assign idx_hit_vec[gi] = (i_cfg_idx == 3'(gi));
            assign locked_vec[gi]  = perm_reg[gi][PERM_L];

            mem_region_match #(.W(W)) u_fetch_match (
                .addr    (i_fetch_addr),
                .base    (base_reg[gi]),
                .limit   (limit_reg[gi]),
                .perm    (perm_reg[gi][2:0]),
                .hit     (f_hit[gi]),
                .allow_x (f_allow_x[gi]),
                .allow_r (f_unused_r[gi]),
                .allow_w (f_unused_w[gi]),
                .offset  (f_offset[gi])
            );

            mem_region_match #(.W(W)) u_ex_match (
                .addr    (i_ex_addr),
                .base    (base_reg[gi]),
                .limit   (limit_reg[gi]),
                .perm    (perm_reg[gi][2:0]),
                .hit     (ex_hit[gi]),
                .allow_x (ex_unused_x[gi]),
                .allow_r (ex_allow_r[gi]),
                .allow_w (ex_allow_w[gi]),
                .offset  (ex_offset[gi])
            );
        end
    endgenerate

    assign idx_valid  = int'(i_cfg_idx) < N_REGIONS;
    // An out-of-range index matches no region, so the lock term is 0 then.
    assign cfg_accept = i_cfg_we && idx_valid && (i_cfg_field != 2'd3)
                        && !(|(idx_hit_vec & locked_vec));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_REGIONS; i++) begin
                base_reg[i]  <= RESET_BASE[i*W +: W];
                limit_reg[i] <= RESET_LIMIT[i*W +: W];
                perm_reg[i]  <= RESET_PERM[i*4 +: 4] & PERM_MASK;
            end
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= i_cfg_we && !cfg_accept;
            if (cfg_accept) begin
                for (int i = 0; i < N_REGIONS; i++) begin
                    if (idx_hit_vec[i]) begin
                        case (i_cfg_field)
                            FIELD_BASE:  base_reg[i]  <= i_cfg_wdata;
                            FIELD_LIMIT: limit_reg[i] <= i_cfg_wdata;
                            FIELD_PERM:  perm_reg[i]  <= i_cfg_wdata[3:0] & PERM_MASK;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign o_cfg_err = cfg_err_reg;

    // ---------------- priority select (lowest index wins) ----------------
    logic [N_REGIONS-1:0] f_sel_next, ex_sel_next;
    logic [W-1:0]         f_xlat_next, ex_xlat_next;
    logic                 f_win_x, ex_win_r, ex_win_w;

    always_comb begin
        f_sel_next   = '0;
        ex_sel_next  = '0;
        f_xlat_next  = i_fetch_addr;
        ex_xlat_next = i_ex_addr;
        f_win_x      = 1'b0;
        ex_win_r     = 1'b0;
        ex_win_w     = 1'b0;
        // Walk downwards so the last (lowest) hit overrides higher ones.
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (f_hit[i]) begin
                f_sel_next    = '0;
                f_sel_next[i] = 1'b1;
                f_xlat_next   = f_offset[i];
                f_win_x       = f_allow_x[i];
            end
            if (ex_hit[i]) begin
                ex_sel_next    = '0;
                ex_sel_next[i] = 1'b1;
                ex_xlat_next   = ex_offset[i];
                ex_win_r       = ex_allow_r[i];
                ex_win_w       = ex_allow_w[i];
            end
        end
    end

    // ---------------- registered lookup outputs ----------------
    logic [N_REGIONS-1:0] f_sel_reg, ex_sel_reg;
    logic [W-1:0]         f_xlat_reg, ex_xlat_reg;
    logic [W-1:0]         f_addr_reg, ex_addr_reg;
    logic                 bad_f_reg, bad_l_reg, bad_s_reg;
    // High when the lookup registers took new values at the last edge; a
    // flag held by a stall is not a new fault.
    logic                 lookup_fresh_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            f_sel_reg        <= '0;
            ex_sel_reg       <= '0;
            f_xlat_reg       <= '0;
            ex_xlat_reg      <= '0;
            f_addr_reg       <= '0;
            ex_addr_reg      <= '0;
            bad_f_reg        <= 1'b0;
            bad_l_reg        <= 1'b0;
            bad_s_reg        <= 1'b0;
            lookup_fresh_reg <= 1'b0;
        end else begin
            lookup_fresh_reg <= !i_stall;
            if (!i_stall) begin
                f_sel_reg   <= f_sel_next;
                ex_sel_reg  <= ex_sel_next;
                f_xlat_reg  <= f_xlat_next;
                ex_xlat_reg <= ex_xlat_next;
                f_addr_reg  <= i_fetch_addr;
                ex_addr_reg <= i_ex_addr;
                bad_f_reg   <= !f_win_x;
                bad_l_reg   <= i_lw_e && !ex_win_r;
                bad_s_reg   <= i_sw_e && !ex_win_w;
            end
        end
    end

    assign o_fetch_sel             = f_sel_reg;
    assign o_ex_sel                = ex_sel_reg;
    assign o_fetch_translated_addr = f_xlat_reg;
    assign o_ex_translated_addr    = ex_xlat_reg;
    assign o_bad_addr_f            = bad_f_reg;
    assign o_bad_addr_load_e       = bad_l_reg;
    assign o_bad_addr_store_e      = bad_s_reg;

    // ---------------- fault capture FSM ----------------
    fault_state_e state_reg, state_next;
    logic         fault_event;
    logic         capture_en;
    logic [1:0]   cause_next, cause_reg;
    logic [W-1:0] addr_next, fault_addr_reg;

    assign fault_event = lookup_fresh_reg && (bad_f_reg || bad_l_reg || bad_s_reg);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_reg <= FAULT_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FAULT_IDLE: if (fault_event) state_next = FAULT_HELD;
            FAULT_HELD: if (i_fault_clr && !fault_event) state_next = FAULT_IDLE;
            default:    state_next = FAULT_IDLE;
        endcase
    end

    always_comb begin
        capture_en = fault_event && ((state_reg == FAULT_IDLE) || i_fault_clr);
        if (bad_l_reg) begin
            cause_next = CAUSE_LOAD;
            addr_next  = ex_addr_reg;
        end else if (bad_s_reg) begin
            cause_next = CAUSE_STORE;
            addr_next  = ex_addr_reg;
        end else begin
            cause_next = CAUSE_FETCH;
            addr_next  = f_addr_reg;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cause_reg      <= '0;
            fault_addr_reg <= '0;
        end else if (capture_en) begin
            cause_reg      <= cause_next;
            fault_addr_reg <= addr_next;
        end
    end

    assign o_fault_valid = (state_reg == FAULT_HELD);
    assign o_fault_cause = cause_reg;
    assign o_fault_addr  = fault_addr_reg;

endmodule

// File: tb/tb_mem_region_mapper.sv
// ---------------------------------------------------------------------------
// tb_mem_region_mapper
// Directed table-driven lookup vectors plus hand-written sequences for
// fault capture, config timing, stall, reset and lock behaviour.
// ---------------------------------------------------------------------------
module tb_mem_region_mapper;

`ifdef MEM_REGION_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [1:0]  cfg_field;
    logic [63:0] cfg_wdata;
    logic        cfg_err;
    logic [63:0] fetch_addr, ex_addr;
    logic        lw_e, sw_e, stall, fault_clr;
    logic [3:0]  fetch_sel, ex_sel;
    logic [63:0] fetch_xl, ex_xl;
    logic        bad_f, bad_l, bad_s;
    logic        fault_valid;
    logic [1:0]  fault_cause;
    logic [63:0] fault_addr;

    always #5 clk = ~clk;

    mem_region_mapper dut (
        .i_clk                   (clk),
        .i_rst                   (rst),
        .i_cfg_we                (cfg_we),
        .i_cfg_idx               (cfg_idx),
        .i_cfg_field             (cfg_field),
        .i_cfg_wdata             (cfg_wdata),
        .o_cfg_err               (cfg_err),
        .i_fetch_addr            (fetch_addr),
        .i_ex_addr               (ex_addr),
        .i_lw_e                  (lw_e),
        .i_sw_e                  (sw_e),
        .i_stall                 (stall),
        .o_fetch_sel             (fetch_sel),
        .o_ex_sel                (ex_sel),
        .o_fetch_translated_addr (fetch_xl),
        .o_ex_translated_addr    (ex_xl),
        .o_bad_addr_f            (bad_f),
        .o_bad_addr_load_e       (bad_l),
        .o_bad_addr_store_e      (bad_s),
        .o_fault_valid           (fault_valid),
        .o_fault_cause           (fault_cause),
        .o_fault_addr            (fault_addr),
        .i_fault_clr             (fault_clr)
    );

    typedef struct {
        logic [63:0] f_addr;
        logic [63:0] e_addr;
        logic        lw;
        logic        sw;
        logic [3:0]  f_sel;
        logic [3:0]  e_sel;
        logic [63:0] f_xl;
        logic [63:0] e_xl;
        logic        bf;
        logic        bl;
        logic        bs;
    } vec_t;

    vec_t vecs [8];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cfg_we     = 1'b0;
        cfg_idx    = 3'd0;
        cfg_field  = 2'd0;
        cfg_wdata  = 64'h0;
        fetch_addr = 64'h0;
        ex_addr    = 64'h0;
        lw_e       = 1'b0;
        sw_e       = 1'b0;
        stall      = 1'b0;
        fault_clr  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [1:0] field, input logic [63:0] data);
        cfg_we    = 1'b1;
        cfg_idx   = idx;
        cfg_field = field;
        cfg_wdata = data;
        step();
        cfg_we    = 1'b0;
    endtask

    initial begin
        // Default map: r0 0..FFF RX, r1 1000..1FFF R, r2 2000..2FFF RW, r3 empty
        vecs[0] = '{64'h0,    64'h2010, 1'b1, 1'b0, 4'b0001, 4'b0100, 64'h0,   64'h10,   1'b0, 1'b0, 1'b0};
        vecs[1] = '{64'h1004, 64'h1008, 1'b0, 1'b1, 4'b0010, 4'b0010, 64'h4,   64'h8,    1'b1, 1'b0, 1'b1};
        vecs[2] = '{64'hFFF,  64'h2FFF, 1'b1, 1'b1, 4'b0001, 4'b0100, 64'hFFF, 64'hFFF,  1'b0, 1'b0, 1'b0};
        vecs[3] = '{64'h3000, 64'h3000, 1'b1, 1'b1, 4'b0000, 4'b0000, 64'h3000, 64'h3000, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{64'h800,  64'h1FFF, 1'b1, 1'b1, 4'b0001, 4'b0010, 64'h800, 64'hFFF,  1'b0, 1'b0, 1'b1};
        vecs[5] = '{64'h2000, 64'h0,    1'b0, 1'b0, 4'b0100, 4'b0001, 64'h0,   64'h0,    1'b1, 1'b0, 1'b0};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1000, 1'b0, 1'b1, 4'b0000, 4'b0010,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{64'h2FFF, 64'h1000, 1'b1, 1'b0, 4'b0100, 4'b0010, 64'hFFF, 64'h0,    1'b1, 1'b0, 1'b0};

        // ---- reset state ----
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_fsel",  64'(fetch_sel), 64'h0);
        check("rst_exsel", 64'(ex_sel), 64'h0);
        check("rst_fxl",   fetch_xl, 64'h0);
        check("rst_exl",   ex_xl, 64'h0);
        check("rst_bad",   64'({bad_f, bad_l, bad_s}), 64'h0);
        check("rst_cfgerr", 64'(cfg_err), 64'h0);
        check("rst_fvalid", 64'(fault_valid), 64'h0);
        check("rst_fcause", 64'(fault_cause), 64'h0);
        check("rst_faddr",  fault_addr, 64'h0);
        rst = 1'b0;

        // ---- table vectors ----
        for (int i = 0; i < 8; i++) begin
            fetch_addr = vecs[i].f_addr;
            ex_addr    = vecs[i].e_addr;
            lw_e       = vecs[i].lw;
            sw_e       = vecs[i].sw;
            step();
            check($sformatf("v%0d_fsel", i),  64'(fetch_sel), 64'(vecs[i].f_sel));
            check($sformatf("v%0d_exsel", i), 64'(ex_sel),    64'(vecs[i].e_sel));
            check($sformatf("v%0d_fxl", i),   fetch_xl,       vecs[i].f_xl);
            check($sformatf("v%0d_exl", i),   ex_xl,          vecs[i].e_xl);
            check($sformatf("v%0d_badf", i),  64'(bad_f),     64'(vecs[i].bf));
            check($sformatf("v%0d_badl", i),  64'(bad_l),     64'(vecs[i].bl));
            check($sformatf("v%0d_bads", i),  64'(bad_s),     64'(vecs[i].bs));
        end

        // ---- bad fetch captured one cycle after the flag ----
        do_reset();
        fetch_addr = 64'h1004;
        step();
        check("fetch_badf", 64'(bad_f), 64'h1);
        check("fetch_valid_early", 64'(fault_valid), 64'h0);
        fetch_addr = 64'h0;
        step();
        check("fetch_valid", 64'(fault_valid), 64'h1);
        check("fetch_cause", 64'(fault_cause), 64'h0);
        check("fetch_addr",  fault_addr, 64'h1004);

        // ---- precedence: load over store over fetch ----
        do_reset();
        fetch_addr = 64'h3000; ex_addr = 64'h3000; lw_e = 1'b1; sw_e = 1'b1;
        step();
        idle();
        step();
        check("prec_lsf_cause", 64'(fault_cause), 64'h1);
        check("prec_lsf_addr",  fault_addr, 64'h3000);
        do_reset();
        fetch_addr = 64'h1004; ex_addr = 64'h1008; lw_e = 1'b1; sw_e = 1'b1;
        step();
        idle();
        step();
        check("prec_sf_cause", 64'(fault_cause), 64'h2);
        check("prec_sf_addr",  fault_addr, 64'h1008);

        // ---- HELD ignores later faults; clr with new fault recaptures ----
        do_reset();
        ex_addr = 64'h3000; lw_e = 1'b1;
        step();
        ex_addr = 64'h4000; lw_e = 1'b0; sw_e = 1'b1;
        step();
        idle();
        step();
        check("held_valid", 64'(fault_valid), 64'h1);
        check("held_cause", 64'(fault_cause), 64'h1);
        check("held_addr",  fault_addr, 64'h3000);
        ex_addr = 64'h5000; lw_e = 1'b1;
        step();
        idle();
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("clrnew_valid", 64'(fault_valid), 64'h1);
        check("clrnew_cause", 64'(fault_cause), 64'h1);
        check("clrnew_addr",  fault_addr, 64'h5000);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("clr_valid", 64'(fault_valid), 64'h0);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("idleclr_valid", 64'(fault_valid), 64'h0);
        check("idleclr_addr",  fault_addr, 64'h5000);

        // ---- reset mid-operation drops held fault and pending write ----
        ex_addr = 64'h3000; lw_e = 1'b1;
        step();
        idle();
        step();
        check("pre_rst_valid", 64'(fault_valid), 64'h1);
        rst = 1'b1;
        cfg_we = 1'b1; cfg_idx = 3'd1; cfg_field = 2'd0; cfg_wdata = 64'h1004;
        #1;
        check("midrst_valid", 64'(fault_valid), 64'h0);
        check("midrst_addr",  fault_addr, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        ex_addr = 64'h1008; lw_e = 1'b1;
        step();
        check("midrst_base_kept", ex_xl, 64'h8);

        // ---- config write at the same edge as a lookup uses old values ----
        idle();
        ex_addr = 64'h2FFF; lw_e = 1'b1;
        cfg_write(3'd2, 2'd1, 64'h2FFE);
        check("same_edge_sel",  64'(ex_sel), 64'h4);
        check("same_edge_badl", 64'(bad_l), 64'h0);
        check("same_edge_xl",   ex_xl, 64'hFFF);
        step();
        check("after_edge_sel",  64'(ex_sel), 64'h0);
        check("after_edge_badl", 64'(bad_l), 64'h1);
        check("after_edge_xl",   ex_xl, 64'h2FFF);

        // ---- overlapping regions: lowest index wins ----
        do_reset();
        cfg_write(3'd1, 2'd0, 64'h0);
        check("ovl_cfgerr", 64'(cfg_err), 64'h0);
        fetch_addr = 64'h800; ex_addr = 64'h800; lw_e = 1'b1;
        step();
        check("ovl_fsel",  64'(fetch_sel), 64'h1);
        check("ovl_exsel", 64'(ex_sel), 64'h1);
        check("ovl_badf",  64'(bad_f), 64'h0);
        ex_addr = 64'h1800;
        step();
        check("ovl_r1_sel", 64'(ex_sel), 64'h2);
        check("ovl_r1_xl",  ex_xl, 64'h1800);

        // ---- lock bit and rejected writes ----
        do_reset();
        cfg_write(3'd1, 2'd2, 64'hB);
        check("perm_cfgerr", 64'(cfg_err), 64'h0);
        ex_addr = 64'h1008; sw_e = 1'b1;
        step();
        check("perm_w_bads", 64'(bad_s), 64'h0);
        cfg_write(3'd1, 2'd0, 64'h1004);
        check("lock_cfgerr", 64'(cfg_err), 64'(LOCK));
        step();
        check("lock_err_pulse", 64'(cfg_err), 64'h0);
        sw_e = 1'b0; lw_e = 1'b1;
        step();
        check("lock_base_xl", ex_xl, LOCK ? 64'h8 : 64'h4);
        cfg_write(3'd5, 2'd0, 64'h0);
        check("idx5_cfgerr", 64'(cfg_err), 64'h1);
        cfg_write(3'd0, 2'd3, 64'h0);
        check("fld3_cfgerr", 64'(cfg_err), 64'h1);
        step();
        check("fld3_pulse", 64'(cfg_err), 64'h0);

        // ---- stalled bad fetch captured once ----
        do_reset();
        fetch_addr = 64'h1004;
        step();
        stall = 1'b1;
        fetch_addr = 64'h0;
        step();
        check("stall_valid",  64'(fault_valid), 64'h1);
        check("stall_cause",  64'(fault_cause), 64'h0);
        check("stall_addr",   fault_addr, 64'h1004);
        check("stall_fsel",   64'(fetch_sel), 64'h2);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("stall_clr_valid", 64'(fault_valid), 64'h0);
        step();
        check("stall_norecap", 64'(fault_valid), 64'h0);
        check("stall_badf_held", 64'(bad_f), 64'h1);
        stall = 1'b0;
        step();
        check("unstall_badf", 64'(bad_f), 64'h0);
        step();
        check("unstall_valid", 64'(fault_valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
